// File: rtl/dcache_controller_pkg.sv
// Shared geometry, FSM encoding and byte-merge helper for the L1 data cache.
package dcache_controller_pkg;

    localparam int TAG_BITS    = 22;
    localparam int INDEX_BITS  = 6;
    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_BITS  = 8 * BLOCK_BYTES;
    localparam int ADDR_BITS   = TAG_BITS + INDEX_BITS;
    localparam int NUM_LINES   = 1 << INDEX_BITS;

    typedef logic [TAG_BITS-1:0]    tag_t;
    typedef logic [INDEX_BITS-1:0]  index_t;
    typedef logic [ADDR_BITS-1:0]   addr_t;
    typedef logic [BLOCK_BITS-1:0]  block_t;
    typedef logic [BLOCK_BYTES-1:0] bsel_t;

    typedef enum logic [1:0] {
        DC_COMPARE   = 2'd0,
        DC_WRITEBACK = 2'd1,
        DC_ALLOCATE  = 2'd2
    } dc_state_e;

    // Byte i of the result comes from new_line when mask[i] is set, else from old_line.
    function automatic block_t byte_merge(input block_t old_line,
                                          input block_t new_line,
                                          input bsel_t  mask);
        block_t res;
        res = old_line;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_line[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_line[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// Pipeline-side and memory-side buses of the data cache.
interface dcache_cpu_if;
    import dcache_controller_pkg::*;

    logic   dcache_ren;
    logic   dcache_wen;
    addr_t  dcache_addr;
    bsel_t  byteSelectVector;
    block_t dcache_input;
    block_t dcache_output;
    logic   dcache_stall;

    // Pipeline MEM stage issues requests.
    modport master (
        output dcache_ren, dcache_wen, dcache_addr, byteSelectVector, dcache_input,
        input  dcache_output, dcache_stall
    );

    // Cache responds.
    modport slave (
        input  dcache_ren, dcache_wen, dcache_addr, byteSelectVector, dcache_input,
        output dcache_output, dcache_stall
    );
endinterface

interface dcache_mem_if;
    import dcache_controller_pkg::*;

    logic   mem_ren;
    logic   mem_wen;
    addr_t  mem_addr;
    block_t mem_wdata;
    block_t mem_rdata;
    logic   mem_ready;

    // Cache issues block reads/writes.
    modport master (
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    // Memory serves them.
    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_line_array.sv
// Direct-mapped line storage: tag/data arrays (no reset), valid/dirty bits (async clear).
module dcache_line_array
    import dcache_controller_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  index_t index,
    output tag_t   rd_tag,
    output block_t rd_data,
    output logic   rd_valid,
    output logic   rd_dirty,
    input  logic   wr_en,
    input  bsel_t  wr_mask,
    input  block_t wr_data,
    input  logic   fill_en,
    input  tag_t   fill_tag,
    input  block_t fill_data,
    input  logic   clr_dirty
);

    tag_t                 tag_q  [NUM_LINES];
    block_t               data_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [NUM_LINES-1:0] dirty_q;
    logic [NUM_LINES-1:0] dirty_d;

    assign rd_tag   = tag_q[index];
    assign rd_data  = data_q[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];

    // Next valid/dirty state: fill makes a clean valid line, a write hit dirties it, writeback cleans it.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en) begin
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
        end else if (wr_en) begin
            dirty_d[index] = 1'b1;
        end else if (clr_dirty) begin
            dirty_d[index] = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Valid/dirty flops; cleared asynchronously so the cache comes up empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= {NUM_LINES{1'b0}};
            dirty_q <= {NUM_LINES{1'b0}};
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag/data storage: full-line fill from memory or byte-masked merge on a write hit.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (wr_en) begin
            data_q[index] <= byte_merge(data_q[index], wr_data, wr_mask);
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);

    dc_state_e state_q, state_d;
    logic      mem_ren_q, mem_ren_d;
    logic      mem_wen_q, mem_wen_d;
    addr_t     mem_addr_q, mem_addr_d;
    block_t    mem_wdata_q, mem_wdata_d;

    tag_t      req_tag_s;
    index_t    req_index_s;
    tag_t      rd_tag_s;
    block_t    rd_data_s;
    logic      rd_valid_s;
    logic      rd_dirty_s;
    logic      request_s;
    logic      hit_s;
    logic      wr_en_s;
    logic      fill_en_s;
    logic      clr_dirty_s;

    assign req_tag_s   = cpu.dcache_addr[ADDR_BITS-1:INDEX_BITS];
    assign req_index_s = cpu.dcache_addr[INDEX_BITS-1:0];
    assign request_s   = cpu.dcache_ren | cpu.dcache_wen;
    assign hit_s       = rd_valid_s & (rd_tag_s == req_tag_s);

    dcache_line_array u_lines (
        .clock     (clock),
        .reset     (reset),
        .index     (req_index_s),
        .rd_tag    (rd_tag_s),
        .rd_data   (rd_data_s),
        .rd_valid  (rd_valid_s),
        .rd_dirty  (rd_dirty_s),
        .wr_en     (wr_en_s),
        .wr_mask   (cpu.byteSelectVector),
        .wr_data   (cpu.dcache_input),
        .fill_en   (fill_en_s),
        .fill_tag  (req_tag_s),
        .fill_data (mem.mem_rdata),
        .clr_dirty (clr_dirty_s)
    );

    // Pipeline-facing outputs: same-cycle hit data and stall, both forced low while in reset.
    always_comb begin
        cpu.dcache_output = {BLOCK_BITS{1'b0}};
        cpu.dcache_stall  = 1'b0;
        if (!reset) begin
            cpu.dcache_output = {BLOCK_BITS{1'b0}};
            cpu.dcache_stall  = 1'b0;
        end else begin
            cpu.dcache_output = hit_s ? rd_data_s : {BLOCK_BITS{1'b0}};
            cpu.dcache_stall  = (state_q != DC_COMPARE) | (request_s & ~hit_s);
        end
    end

    assign mem.mem_ren   = mem_ren_q;
    assign mem.mem_wen   = mem_wen_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    // Next state, array strobes and next memory-port values; a single edge hands
    // WRITEBACK over to ALLOCATE so mem_wen and mem_ren never overlap.
    always_comb begin
        state_d     = state_q;
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_en_s     = 1'b0;
        fill_en_s   = 1'b0;
        clr_dirty_s = 1'b0;
        case (state_q)
            DC_COMPARE: begin
                if (request_s && !hit_s) begin
                    if (rd_valid_s && rd_dirty_s) begin
                        state_d     = DC_WRITEBACK;
                        mem_wen_d   = 1'b1;
                        mem_addr_d  = {rd_tag_s, req_index_s};
                        mem_wdata_d = rd_data_s;
                    end else begin
                        state_d    = DC_ALLOCATE;
                        mem_ren_d  = 1'b1;
                        mem_addr_d = cpu.dcache_addr;
                    end
                end else if (hit_s && cpu.dcache_wen) begin
                    wr_en_s = 1'b1;
                end else begin
                    state_d = DC_COMPARE;
                end
            end
            DC_WRITEBACK: begin
                if (mem.mem_ready) begin
                    clr_dirty_s = 1'b1;
                    state_d     = DC_ALLOCATE;
                    mem_wen_d   = 1'b0;
                    mem_ren_d   = 1'b1;
                    mem_addr_d  = cpu.dcache_addr;
                end else begin
                    state_d = DC_WRITEBACK;
                end
            end
            DC_ALLOCATE: begin
                if (mem.mem_ready) begin
                    fill_en_s = 1'b1;
                    mem_ren_d = 1'b0;
                    state_d   = DC_COMPARE;
                end else begin
                    state_d = DC_ALLOCATE;
                end
            end
            default: begin
                state_d   = DC_COMPARE;
                mem_ren_d = 1'b0;
                mem_wen_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered memory-port signals; reset abandons any memory request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= DC_COMPARE;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= {ADDR_BITS{1'b0}};
            mem_wdata_q <= {BLOCK_BITS{1'b0}};
        end else begin
            state_q     <= state_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule
